// File: rtl/cpu_run_pkg.sv
// ----------------------------------------------------------------------------
// cpu_run_pkg: shared state encoding and default limits for cpu_run_monitor
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_run_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE    = 2'd0;
    localparam state_t c_ST_RST_SEQ = 2'd1;
    localparam state_t c_ST_RUN     = 2'd2;
    localparam state_t c_ST_DONE    = 2'd3;

    localparam int c_DEF_MAX_CLOCKS   = 100000000;
    localparam int c_DEF_RESET_CYCLES = 4;
    localparam int c_DEF_STALL_LIMIT  = 8;

endpackage

`default_nettype wire

// File: rtl/core_cycle_tracker.sv
// ----------------------------------------------------------------------------
// core_cycle_tracker: per-core cycle counter with halt and PC self-loop detect
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module core_cycle_tracker #(
    parameter int PC_WIDTH    = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int STALL_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 run_en,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 halt,
    output logic                 halted,
    output logic                 halting,
    output logic [CNT_WIDTH-1:0] cycles
);

    localparam int c_STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(STALL_LIMIT - 1);

    logic [PC_WIDTH-1:0]  r_last_pc;
    logic                 r_pc_valid;
    logic [c_STALL_W-1:0] r_stall_cnt;
    logic                 r_halted;
    logic [CNT_WIDTH-1:0] r_cycles;

    logic w_same_pc;
    logic w_stall_hit;

    assign w_same_pc   = r_pc_valid && (pc == r_last_pc);
    // Halts on the sample that would bring the stall count up to the limit.
    assign w_stall_hit = w_same_pc && (r_stall_cnt == c_STALL_LAST);
    assign halting     = run_en && !r_halted && (halt || w_stall_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_pc   <= '0;
            r_pc_valid  <= 1'b0;
            r_stall_cnt <= '0;
            r_halted    <= 1'b0;
            r_cycles    <= '0;
        end else if (clear) begin
            r_last_pc   <= '0;
            r_pc_valid  <= 1'b0;
            r_stall_cnt <= '0;
            r_halted    <= 1'b0;
            r_cycles    <= '0;
        end else if (run_en && !r_halted) begin
            if (r_cycles != '1) begin
                r_cycles <= r_cycles + CNT_WIDTH'(1);
            end
            r_last_pc   <= pc;
            r_pc_valid  <= 1'b1;
            r_stall_cnt <= w_same_pc ? (r_stall_cnt + c_STALL_W'(1)) : '0;
            if (halt || w_stall_hit) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign halted = r_halted;
    assign cycles = r_cycles;

endmodule

`default_nettype wire

// File: rtl/cpu_run_monitor.sv
// ----------------------------------------------------------------------------
// cpu_run_monitor: core reset sequencer, run FSM and global clock budget
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cpu_run_monitor
    import cpu_run_pkg::*;
#(
    parameter int NUM_CORES    = 2,
    parameter int PC_WIDTH     = 32,
    parameter int CNT_WIDTH    = 32,
    parameter int RESET_CYCLES = c_DEF_RESET_CYCLES,
    parameter int MAX_CLOCKS   = c_DEF_MAX_CLOCKS,
    parameter int STALL_LIMIT  = c_DEF_STALL_LIMIT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_CORES*PC_WIDTH-1:0]  pc,
    input  logic [NUM_CORES-1:0]           halt,
    output logic                           core_rst_n,
    output logic                           busy,
    output logic                           done,
    output logic                           timeout,
    output logic [NUM_CORES-1:0]           halted,
    output logic [NUM_CORES*CNT_WIDTH-1:0] cycles_consumed,
    output logic [CNT_WIDTH-1:0]           global_cycles
);

    localparam int c_RST_W = $clog2(RESET_CYCLES + 1);
    localparam logic [c_RST_W-1:0]   c_RST_LAST = c_RST_W'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_MAX_LAST = CNT_WIDTH'(MAX_CLOCKS - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_RST_W-1:0]   r_rst_cnt;
    logic [CNT_WIDTH-1:0] r_global;
    logic                 r_core_rst_n, r_busy, r_done, r_timeout;
    logic                 w_core_rst_n_next, w_busy_next, w_done_next, w_timeout_next;
    logic [NUM_CORES-1:0] w_halted;
    logic [NUM_CORES-1:0] w_halting;
    logic                 w_start_ok;
    logic                 w_run_en;
    logic                 w_all_halting;
    logic                 w_budget_hit;

    assign w_start_ok    = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_run_en      = (r_state == c_ST_RUN);
    assign w_all_halting = &(w_halted | w_halting);
    assign w_budget_hit  = (r_global == c_MAX_LAST);

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        core_cycle_tracker #(
            .PC_WIDTH    (PC_WIDTH),
            .CNT_WIDTH   (CNT_WIDTH),
            .STALL_LIMIT (STALL_LIMIT)
        ) u_tracker (
            .clk     (clk),
            .rst     (rst),
            .clear   (w_start_ok),
            .run_en  (w_run_en),
            .pc      (pc[gi*PC_WIDTH +: PC_WIDTH]),
            .halt    (halt[gi]),
            .halted  (w_halted[gi]),
            .halting (w_halting[gi]),
            .cycles  (cycles_consumed[gi*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_core_rst_n <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_core_rst_n <= w_core_rst_n_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_timeout    <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: if (start) w_state_next = c_ST_RST_SEQ;
            c_ST_RST_SEQ:         if (r_rst_cnt == c_RST_LAST) w_state_next = c_ST_RUN;
            c_ST_RUN:             if (w_all_halting || w_budget_hit) w_state_next = c_ST_DONE;
            default:              w_state_next = c_ST_IDLE;
        endcase
    end

    // Outputs decode the upcoming state so they stay registered without lag.
    always_comb begin
        w_core_rst_n_next = (w_state_next == c_ST_RUN) || (w_state_next == c_ST_DONE);
        w_busy_next       = (w_state_next == c_ST_RST_SEQ) || (w_state_next == c_ST_RUN);
        w_done_next       = (w_state_next == c_ST_DONE);
        w_timeout_next    = 1'b0;
        if ((r_state == c_ST_RUN) && (w_state_next == c_ST_DONE)) begin
            w_timeout_next = !w_all_halting;
        end else if ((r_state == c_ST_DONE) && (w_state_next == c_ST_DONE)) begin
            w_timeout_next = r_timeout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_cnt <= '0;
            r_global  <= '0;
        end else if (w_start_ok) begin
            r_rst_cnt <= '0;
            r_global  <= '0;
        end else if (r_state == c_ST_RST_SEQ) begin
            r_rst_cnt <= r_rst_cnt + c_RST_W'(1);
        end else if (w_run_en) begin
            r_global <= r_global + CNT_WIDTH'(1);
        end
    end

    assign core_rst_n    = r_core_rst_n;
    assign busy          = r_busy;
    assign done          = r_done;
    assign timeout       = r_timeout;
    assign halted        = w_halted;
    assign global_cycles = r_global;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_monitor.sv
// ----------------------------------------------------------------------------
// tb_cpu_run_monitor: directed runs with a done-triggered scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cpu_run_monitor;

    localparam int NC = 2;
    localparam int PW = 32;
    localparam int CW = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [NC*PW-1:0] pc = '0;
    logic [NC-1:0]    halt = '0;
    logic             core_rst_n, busy, done, timeout;
    logic [NC-1:0]    halted;
    logic [NC*CW-1:0] cycles_consumed;
    logic [CW-1:0]    global_cycles;

    typedef struct packed {
        logic [1:0]  halted;
        logic        timeout;
        logic [31:0] cyc0;
        logic [31:0] cyc1;
        logic [31:0] glob;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    cpu_run_monitor #(
        .NUM_CORES    (NC),
        .PC_WIDTH     (PW),
        .CNT_WIDTH    (CW),
        .RESET_CYCLES (4),
        .MAX_CLOCKS   (1000),
        .STALL_LIMIT  (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .pc              (pc),
        .halt            (halt),
        .core_rst_n      (core_rst_n),
        .busy            (busy),
        .done            (done),
        .timeout         (timeout),
        .halted          (halted),
        .cycles_consumed (cycles_consumed),
        .global_cycles   (global_cycles)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_timeout"},    32'(timeout),    32'd0);
        check({tag, "_halted"},     32'(halted),     32'd0);
        check({tag, "_cyc0"},       cycles_consumed[31:0],  32'd0);
        check({tag, "_cyc1"},       cycles_consumed[63:32], 32'd0);
        check({tag, "_global"},     global_cycles,   32'd0);
    endtask

    // Monitor: compares each completed run against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done && !prev_done) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 at global=%0d expected no completion", global_cycles);
                end else begin
                    e = sb_q.pop_front();
                    check("done_timeout",    32'(timeout),          32'(e.timeout));
                    check("done_halted",     32'(halted),           32'(e.halted));
                    check("done_cyc0",       cycles_consumed[31:0],  e.cyc0);
                    check("done_cyc1",       cycles_consumed[63:32], e.cyc1);
                    check("done_global",     global_cycles,          e.glob);
                    check("done_busy",       32'(busy),             32'd0);
                    check("done_core_rst_n", 32'(core_rst_n),       32'd1);
                end
            end
            prev_done = done;
        end
    end

    // h0/h1: RUN cycle at which halt[i] rises (0 = never); lim: RUN edges to drive.
    task automatic run_case(input string tag, input int h0, input int h1, input int lim,
                            input bit loop0, input bit expect_done,
                            input logic [1:0] e_halted, input logic e_to,
                            input int e_c0, input int e_c1, input int e_glob);
        int p0;
        int p1;
        exp_t e;
        if (expect_done) begin
            e.halted  = e_halted;
            e.timeout = e_to;
            e.cyc0    = 32'(e_c0);
            e.cyc1    = 32'(e_c1);
            e.glob    = 32'(e_glob);
            sb_q.push_back(e);
        end
        // halt and pc garbage during reset sequencing must be ignored
        start = 1'b1;
        halt  = 2'b11;
        pc    = {32'hffff_fff0, 32'hffff_fff0};
        tick();
        start = 1'b0;
        check({tag, "_seq_busy"},   32'(busy),       32'd1);
        check({tag, "_seq_rst_n0"}, 32'(core_rst_n), 32'd0);
        check({tag, "_seq_done"},   32'(done),       32'd0);
        check({tag, "_seq_global"}, global_cycles,   32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check({tag, "_seq_rst_n_low"}, 32'(core_rst_n), 32'd0);
        end
        tick();
        check({tag, "_run_rst_n1"}, 32'(core_rst_n), 32'd1);
        check({tag, "_run_busy"},   32'(busy),       32'd1);
        for (int n = 0; n < lim; n++) begin
            p0 = loop0 ? ((4 * n > 64) ? 64 : 4 * n) : 4 * n;
            p1 = 32'h1000 + 4 * n;
            pc = {32'(p1), 32'(p0)};
            halt = {(h1 != 0) && (n + 1 >= h1), (h0 != 0) && (n + 1 >= h0)};
            start = (n == 2);
            tick();
        end
        start = 1'b0;
        if (expect_done) begin
            for (int k = 0; k < 2; k++) begin
                pc   = {32'hdead_0000 + 32'(k), 32'hbeef_0000 + 32'(k)};
                halt = 2'b11;
                tick();
            end
            n_cmp++;
            if (sb_q.size() != 0) begin
                n_err++;
                $display("FAIL %s_done_missing: got %0d pending results expected 0", tag, sb_q.size());
                sb_q.delete();
            end
            check({tag, "_hold_global"}, global_cycles,          32'(e_glob));
            check({tag, "_hold_cyc0"},   cycles_consumed[31:0],  32'(e_c0));
            check({tag, "_hold_done"},   32'(done),             32'd1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_cleared("por");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_cleared("idle");

        run_case("halt",    20,   35,   35, 1'b0, 1'b1, 2'b11, 1'b0,   20,   35,   35);
        run_case("loop",     0,    5,   25, 1'b1, 1'b1, 2'b11, 1'b0,   25,    5,   25);
        run_case("tmo",      0,    0, 1000, 1'b0, 1'b1, 2'b00, 1'b1, 1000, 1000, 1000);
        run_case("tie",   1000,   10, 1000, 1'b0, 1'b1, 2'b11, 1'b0, 1000,   10, 1000);

        run_case("mid",      0,    0,   50, 1'b0, 1'b0, 2'b00, 1'b0,    0,    0,    0);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("midrst");
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_case("rerun",    7,    3,    7, 1'b0, 1'b1, 2'b11, 1'b0,    7,    3,    7);
        run_case("fromdone", 2,    6,    6, 1'b0, 1'b1, 2'b11, 1'b0,    2,    6,    6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
